// File: rtl/config_ctrl_mc.sv
// Multi-channel configuration controller: decodes config flits from a credit-managed
// FIFO into channel writes, burst writes and burst reads, returning read data as response flits.
module config_ctrl_mc #(
    parameter int unsigned FW  = 59,
    parameter int unsigned FTW = 3,
    parameter int unsigned CHW = 2,
    parameter int unsigned NCH = 4,
    parameter int unsigned CAW = 15,
    parameter int unsigned CDW = 21,
    parameter int unsigned LW  = 4,
    parameter int unsigned XW  = 4,
    parameter int unsigned YW  = 4,
    parameter int unsigned IFD = 4,
    parameter int unsigned RL  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_we,
    input  logic [FW-1:0]      in_wdata,
    output logic               in_credit,
    input  logic               work_busy,
    output logic [NCH-1:0]     cfg_we,
    output logic [CAW-1:0]     cfg_waddr,
    output logic [CDW-1:0]     cfg_wdata,
    output logic [NCH-1:0]     cfg_re,
    output logic [CAW-1:0]     cfg_raddr,
    input  logic [NCH*CDW-1:0] cfg_rdata,
    input  logic               out_full,
    output logic               out_we,
    output logic [FW-1:0]      out_wdata,
    output logic               busy,
    output logic               ovf,
    output logic [7:0]         err_cnt
);
    localparam int unsigned CH_LSB = FW - FTW - CHW;
    localparam int unsigned AD_LSB = CH_LSB - CAW;
    localparam int unsigned DT_LSB = AD_LSB - CDW;
    localparam int unsigned LN_LSB = DT_LSB - LW;
    localparam int unsigned X_LSB  = LN_LSB - XW;
    localparam int unsigned Y_LSB  = X_LSB - YW;
    localparam int unsigned PW     = (IFD > 1) ? $clog2(IFD) : 1;
    localparam int unsigned CW     = $clog2(IFD + 1);
    localparam int unsigned WTW    = $clog2(RL + 1);

    localparam logic [FTW-1:0] T_WR   = FTW'(0);
    localparam logic [FTW-1:0] T_WRB  = FTW'(1);
    localparam logic [FTW-1:0] T_DATA = FTW'(2);
    localparam logic [FTW-1:0] T_RD   = FTW'(3);
    localparam logic [FTW-1:0] T_RSP  = FTW'(7);
    localparam logic [CHW:0]   NCH_C  = (CHW+1)'(NCH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WB   = 3'd1;
    localparam logic [2:0] S_RI   = 3'd2;
    localparam logic [2:0] S_RW   = 3'd3;
    localparam logic [2:0] S_RS   = 3'd4;

    logic [FW-1:0]  mem_q [IFD];
    logic [FW-1:0]  mem_d [IFD];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  fcnt_q, fcnt_d;
    logic           ovf_q, ovf_d;
    logic           empty, full, push, pop;

    logic [2:0]     state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CAW-1:0] addr_q, addr_d;
    logic [LW-1:0]  len_q, len_d;
    logic [XW-1:0]  ret_x_q, ret_x_d;
    logic [YW-1:0]  ret_y_q, ret_y_d;
    logic           drop_q, drop_d;
    logic [WTW-1:0] wait_q, wait_d;
    logic [CDW-1:0] hold_q, hold_d;

    logic [NCH-1:0] cfg_we_q, cfg_we_d, cfg_re_q, cfg_re_d;
    logic [CAW-1:0] cfg_waddr_q, cfg_waddr_d, cfg_raddr_q, cfg_raddr_d;
    logic [CDW-1:0] cfg_wdata_q, cfg_wdata_d;
    logic           out_we_q, out_we_d;
    logic [FW-1:0]  out_wdata_q, out_wdata_d;
    logic           credit_q;
    logic [7:0]     err_q, err_d;

    logic [FW-1:0]  head, rsp;
    logic [FTW-1:0] h_type;
    logic [CHW-1:0] h_ch;
    logic [CAW-1:0] h_addr;
    logic [CDW-1:0] h_data;
    logic [LW-1:0]  h_len;
    logic [XW-1:0]  h_x;
    logic [YW-1:0]  h_y;
    logic           h_ch_ok, err_inc, emit;
    logic [NCH-1:0] h_sel, q_sel;
    logic [CDW-1:0] rdata_sel, emit_data;
    logic           unused_rsv;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(IFD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (fcnt_q == '0);
    assign full    = (fcnt_q == CW'(IFD));
    assign head    = mem_q[rd_ptr_q];
    assign h_type  = head[FW-1 -: FTW];
    assign h_ch    = head[CH_LSB +: CHW];
    assign h_addr  = head[AD_LSB +: CAW];
    assign h_data  = head[DT_LSB +: CDW];
    assign h_len   = head[LN_LSB +: LW];
    assign h_x     = head[X_LSB +: XW];
    assign h_y     = head[Y_LSB +: YW];
    assign h_ch_ok = ({1'b0, h_ch} < NCH_C);
    assign h_sel   = NCH'(1) << h_ch;
    assign q_sel   = NCH'(1) << ch_q;
    assign unused_rsv = ^head[Y_LSB-1:0];

    always_comb begin
        rdata_sel = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (ch_q == CHW'(k)) rdata_sel = cfg_rdata[k*CDW +: CDW];
        end
    end

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        push     = in_we && (!full || pop);
        ovf_d    = ovf_q | (in_we && full && !pop);
        if (push) begin
            mem_d[wr_ptr_q] = in_wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        addr_d      = addr_q;
        len_d       = len_q;
        ret_x_d     = ret_x_q;
        ret_y_d     = ret_y_q;
        drop_d      = drop_q;
        wait_d      = wait_q;
        hold_d      = hold_q;
        cfg_we_d    = '0;
        cfg_waddr_d = cfg_waddr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_re_d    = '0;
        cfg_raddr_d = cfg_raddr_q;
        out_we_d    = 1'b0;
        out_wdata_d = out_wdata_q;
        pop         = 1'b0;
        err_inc     = 1'b0;
        emit        = 1'b0;
        emit_data   = hold_q;

        case (state_q)
            S_IDLE: begin
                if (!empty && !work_busy) begin
                    pop = 1'b1;
                    case (h_type)
                        T_WR: begin
                            if (h_ch_ok) begin
                                cfg_we_d    = h_sel;
                                cfg_waddr_d = h_addr;
                                cfg_wdata_d = h_data;
                            end else begin
                                err_inc = 1'b1;
                            end
                        end
                        T_WRB: begin
                            ch_d    = h_ch;
                            addr_d  = h_addr;
                            len_d   = h_len;
                            drop_d  = !h_ch_ok;
                            err_inc = !h_ch_ok;
                            state_d = S_WB;
                        end
                        // The first read issues straight from the pop so cfg_re follows it by one cycle.
                        T_RD: begin
                            if (h_ch_ok) begin
                                ch_d        = h_ch;
                                addr_d      = h_addr;
                                len_d       = h_len;
                                ret_x_d     = h_x;
                                ret_y_d     = h_y;
                                cfg_re_d    = h_sel;
                                cfg_raddr_d = h_addr;
                                wait_d      = WTW'(RL);
                                state_d     = S_RW;
                            end else begin
                                err_inc = 1'b1;
                            end
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            S_WB: begin
                if (!empty) begin
                    if (h_type != T_DATA) begin
                        err_inc = 1'b1;
                        state_d = S_IDLE;
                    end else if (!work_busy) begin
                        pop = 1'b1;
                        if (!drop_q) begin
                            cfg_we_d    = q_sel;
                            cfg_waddr_d = addr_q;
                            cfg_wdata_d = h_data;
                        end
                        addr_d = addr_q + CAW'(1);
                        if (len_q == '0) state_d = S_IDLE;
                        else             len_d   = len_q - LW'(1);
                    end
                end
            end
            S_RI: begin
                if (!work_busy) begin
                    cfg_re_d    = q_sel;
                    cfg_raddr_d = addr_q;
                    wait_d      = WTW'(RL);
                    state_d     = S_RW;
                end
            end
            // Read data bypasses the hold register when the output is free on the capture cycle.
            S_RW: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WTW'(1);
                end else begin
                    hold_d    = rdata_sel;
                    emit_data = rdata_sel;
                    if (!out_full) emit = 1'b1;
                    else           state_d = S_RS;
                end
            end
            S_RS: begin
                if (!out_full) emit = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        rsp                   = '0;
        rsp[FW-1 -: FTW]      = T_RSP;
        rsp[CH_LSB +: CHW]    = ch_q;
        rsp[AD_LSB +: CAW]    = addr_q;
        rsp[DT_LSB +: CDW]    = emit_data;
        rsp[X_LSB +: XW]      = ret_x_q;
        rsp[Y_LSB +: YW]      = ret_y_q;
        if (emit) begin
            out_we_d    = 1'b1;
            out_wdata_d = rsp;
            addr_d      = addr_q + CAW'(1);
            if (len_q == '0) begin
                state_d = S_IDLE;
            end else begin
                len_d   = len_q - LW'(1);
                state_d = S_RI;
            end
        end

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fcnt_q      <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
            ch_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            ret_x_q     <= '0;
            ret_y_q     <= '0;
            drop_q      <= 1'b0;
            wait_q      <= '0;
            hold_q      <= '0;
            cfg_we_q    <= '0;
            cfg_waddr_q <= '0;
            cfg_wdata_q <= '0;
            cfg_re_q    <= '0;
            cfg_raddr_q <= '0;
            out_we_q    <= 1'b0;
            out_wdata_q <= '0;
            credit_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fcnt_q      <= fcnt_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            ret_x_q     <= ret_x_d;
            ret_y_q     <= ret_y_d;
            drop_q      <= drop_d;
            wait_q      <= wait_d;
            hold_q      <= hold_d;
            cfg_we_q    <= cfg_we_d;
            cfg_waddr_q <= cfg_waddr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_re_q    <= cfg_re_d;
            cfg_raddr_q <= cfg_raddr_d;
            out_we_q    <= out_we_d;
            out_wdata_q <= out_wdata_d;
            credit_q    <= pop;
            err_q       <= err_d;
        end
    end

    assign in_credit = credit_q;
    assign cfg_we    = cfg_we_q;
    assign cfg_waddr = cfg_waddr_q;
    assign cfg_wdata = cfg_wdata_q;
    assign cfg_re    = cfg_re_q;
    assign cfg_raddr = cfg_raddr_q;
    assign out_we    = out_we_q;
    assign out_wdata = out_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign ovf       = ovf_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_config_ctrl_mc.sv
// Directed bench for config_ctrl_mc with three channels, RL=1 and a 4-deep input FIFO.
module tb_config_ctrl_mc;
    localparam int unsigned FW  = 59;
    localparam int unsigned NCH = 3;
    localparam int unsigned CAW = 15;
    localparam int unsigned CDW = 21;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_we;
    logic [FW-1:0]      in_wdata;
    logic               in_credit;
    logic               work_busy;
    logic [NCH-1:0]     cfg_we;
    logic [CAW-1:0]     cfg_waddr;
    logic [CDW-1:0]     cfg_wdata;
    logic [NCH-1:0]     cfg_re;
    logic [CAW-1:0]     cfg_raddr;
    logic [NCH*CDW-1:0] cfg_rdata;
    logic               out_full;
    logic               out_we;
    logic [FW-1:0]      out_wdata;
    logic               busy;
    logic               ovf;
    logic [7:0]         err_cnt;

    config_ctrl_mc #(.NCH(NCH), .RL(1), .IFD(4)) dut (
        .clk(clk), .rst(rst), .in_we(in_we), .in_wdata(in_wdata), .in_credit(in_credit),
        .work_busy(work_busy), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
        .cfg_re(cfg_re), .cfg_raddr(cfg_raddr), .cfg_rdata(cfg_rdata), .out_full(out_full),
        .out_we(out_we), .out_wdata(out_wdata), .busy(busy), .ovf(ovf), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [NCH-1:0] we; logic [CAW-1:0] a; logic [CDW-1:0] d; int t; } wr_t;
    typedef struct { logic [FW-1:0] f; int t; } rs_t;

    wr_t wq[$];
    rs_t rq[$];
    int  cyc = 0;
    int  credits = 0;
    int  n_chk = 0;
    int  n_err = 0;

    function automatic logic [FW-1:0] mk(input logic [2:0] ty, input logic [1:0] ch,
                                         input logic [14:0] a, input logic [20:0] d,
                                         input logic [3:0] len, input logic [3:0] x,
                                         input logic [3:0] y);
        return {ty, ch, a, d, len, x, y, 6'b0};
    endfunction

    // Channel contents seen by reads.
    function automatic logic [CDW-1:0] rdval(input int k, input logic [CAW-1:0] a);
        if (k == 0 && a == 15'd5) return 21'h0000AA;
        if (k == 0 && a == 15'd6) return 21'h0000BB;
        return {6'(k), a} ^ 21'h00A5A5;
    endfunction

    always @(posedge clk) begin
        if (rst) cfg_rdata <= '0;
        else begin
            for (int k = 0; k < NCH; k++)
                if (cfg_re[k]) cfg_rdata[k*CDW +: CDW] <= rdval(k, cfg_raddr);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_we != '0) wq.push_back('{cfg_we, cfg_waddr, cfg_wdata, cyc});
            if (out_we) rq.push_back('{out_wdata, cyc});
            if (in_credit) credits++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t pop_wr();
        wr_t w;
        w = '{we: '0, a: '0, d: '0, t: -1};
        if (wq.size() > 0) w = wq.pop_front();
        return w;
    endfunction

    function automatic rs_t pop_rs();
        rs_t r;
        r = '{f: '0, t: -1};
        if (rq.size() > 0) r = rq.pop_front();
        return r;
    endfunction

    task automatic send(input logic [FW-1:0] f);
        in_we    = 1'b1;
        in_wdata = f;
        @(posedge clk);
        #1;
        in_we    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int t, tr, c0;
        wr_t w;
        rs_t r;
        logic [CAW-1:0] atbl [3];

        rst = 1'b1; in_we = 1'b0; in_wdata = '0; work_busy = 1'b0; out_full = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_strobes", 64'({cfg_we, cfg_re, out_we, in_credit, busy, ovf}), 64'(0));
        check("rst_out_wdata", 64'(out_wdata), 64'(0));
        check("rst_cfg_fields", 64'({cfg_waddr, cfg_wdata, cfg_raddr}), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));

        // Single write
        c0 = credits; t = cyc;
        send(mk(3'b000, 2'd1, 15'h0010, 21'h15A5A, 4'd0, 4'd0, 4'd0));
        idle(6);
        check("wr_count", 64'(wq.size()), 64'(1));
        w = pop_wr();
        check("wr_we", 64'(w.we), 64'(3'b010));
        check("wr_addr", 64'(w.a), 64'(15'h0010));
        check("wr_data", 64'(w.d), 64'(21'h15A5A));
        check("wr_time", 64'(w.t), 64'(t + 2));
        check("wr_credit", 64'(credits - c0), 64'(1));

        // Burst write wrapping the address space
        c0 = credits;
        atbl = '{15'h7FFE, 15'h7FFF, 15'h0000};
        send(mk(3'b001, 2'd2, 15'h7FFE, 21'h0, 4'd2, 4'd0, 4'd0));
        for (int i = 1; i <= 3; i++) send(mk(3'b010, 2'd0, 15'h0, 21'(i), 4'd0, 4'd0, 4'd0));
        idle(8);
        check("wrb_count", 64'(wq.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            w = pop_wr();
            check("wrb_we", 64'(w.we), 64'(3'b100));
            check("wrb_addr", 64'(w.a), 64'(atbl[i]));
            check("wrb_data", 64'(w.d), 64'(i + 1));
        end
        check("wrb_credit", 64'(credits - c0), 64'(4));

        // Burst read stalled by out_full
        out_full = 1'b1;
        send(mk(3'b011, 2'd0, 15'd5, 21'd0, 4'd1, 4'd3, 4'd9));
        idle(4);
        check("rd_held", 64'(rq.size()), 64'(0));
        check("rd_busy", 64'(busy), 64'(1));
        out_full = 1'b0;
        idle(10);
        check("rd_count", 64'(rq.size()), 64'(2));
        r = pop_rs();
        check("rd_rsp0", 64'(r.f), 64'(mk(3'b111, 2'd0, 15'd5, 21'h0000AA, 4'd0, 4'd3, 4'd9)));
        r = pop_rs();
        check("rd_rsp1", 64'(r.f), 64'(mk(3'b111, 2'd0, 15'd6, 21'h0000BB, 4'd0, 4'd3, 4'd9)));
        check("rd_idle", 64'(busy), 64'(0));

        // Unstalled burst read: latency and per-word spacing
        t = cyc;
        atbl = '{15'h7FFF, 15'h0000, 15'h0001};
        send(mk(3'b011, 2'd2, 15'h7FFF, 21'd0, 4'd2, 4'hF, 4'h0));
        idle(14);
        check("rdb_count", 64'(rq.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            r = pop_rs();
            check("rdb_flit", 64'(r.f), 64'(mk(3'b111, 2'd2, atbl[i], rdval(2, atbl[i]), 4'd0, 4'hF, 4'h0)));
            check("rdb_time", 64'(r.t), 64'(t + 4 + 3 * i));
        end

        // work_busy stalls channel access and credits
        work_busy = 1'b1; c0 = credits;
        for (int i = 0; i < 3; i++) send(mk(3'b000, 2'd0, 15'(32'h100 + i), 21'(32'h300 + i), 4'd0, 4'd0, 4'd0));
        idle(5);
        check("wbusy_no_wr", 64'(wq.size()), 64'(0));
        check("wbusy_no_credit", 64'(credits - c0), 64'(0));
        tr = cyc; work_busy = 1'b0;
        idle(6);
        check("wbusy_count", 64'(wq.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            w = pop_wr();
            check("wbusy_we", 64'(w.we), 64'(3'b001));
            check("wbusy_addr", 64'(w.a), 64'(32'h100 + i));
            check("wbusy_data", 64'(w.d), 64'(32'h300 + i));
            check("wbusy_time", 64'(w.t), 64'(tr + 1 + i));
        end
        check("wbusy_credit", 64'(credits - c0), 64'(3));
        check("wbusy_no_ovf", 64'(ovf), 64'(0));

        // FIFO overflow drops the fifth flit
        work_busy = 1'b1; c0 = credits;
        for (int i = 0; i < 5; i++) send(mk(3'b000, 2'd1, 15'(32'h200 + i), 21'(32'h400 + i), 4'd0, 4'd0, 4'd0));
        check("ovf_set", 64'(ovf), 64'(1));
        check("ovf_no_credit", 64'(credits - c0), 64'(0));
        work_busy = 1'b0;
        idle(8);
        check("ovf_count", 64'(wq.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            w = pop_wr();
            check("ovf_addr", 64'(w.a), 64'(32'h200 + i));
        end
        check("ovf_credit", 64'(credits - c0), 64'(4));
        check("ovf_sticky", 64'(ovf), 64'(1));

        // Malformed commands: bad type, bad channel, stray DATA
        c0 = credits;
        send(mk(3'b101, 2'd0, 15'h1, 21'h1, 4'd0, 4'd0, 4'd0));
        send(mk(3'b000, 2'd3, 15'h1, 21'h1, 4'd0, 4'd0, 4'd0));
        send(mk(3'b010, 2'd0, 15'h1, 21'h1, 4'd0, 4'd0, 4'd0));
        idle(6);
        check("err_three", 64'(err_cnt), 64'(3));
        check("err_no_wr", 64'(wq.size()), 64'(0));
        check("err_credit", 64'(credits - c0), 64'(3));

        // Burst write to a missing channel discards its data flits
        c0 = credits;
        send(mk(3'b001, 2'd3, 15'h20, 21'h0, 4'd1, 4'd0, 4'd0));
        send(mk(3'b010, 2'd0, 15'h0, 21'h7, 4'd0, 4'd0, 4'd0));
        send(mk(3'b010, 2'd0, 15'h0, 21'h8, 4'd0, 4'd0, 4'd0));
        idle(6);
        check("drop_err", 64'(err_cnt), 64'(4));
        check("drop_no_wr", 64'(wq.size()), 64'(0));
        check("drop_credit", 64'(credits - c0), 64'(3));

        // Burst aborted by a non-DATA head, which is then executed from IDLE
        c0 = credits;
        send(mk(3'b001, 2'd1, 15'h40, 21'h0, 4'd2, 4'd0, 4'd0));
        send(mk(3'b010, 2'd0, 15'h0, 21'h11, 4'd0, 4'd0, 4'd0));
        send(mk(3'b000, 2'd0, 15'h50, 21'h22, 4'd0, 4'd0, 4'd0));
        idle(8);
        check("abort_err", 64'(err_cnt), 64'(5));
        check("abort_count", 64'(wq.size()), 64'(2));
        w = pop_wr();
        check("abort_w0", 64'({w.we, w.a, w.d}), 64'({3'b010, 15'h40, 21'h11}));
        w = pop_wr();
        check("abort_w1", 64'({w.we, w.a, w.d}), 64'({3'b001, 15'h50, 21'h22}));
        check("abort_credit", 64'(credits - c0), 64'(3));
        check("abort_idle", 64'(busy), 64'(0));

        // Read from a missing channel sends nothing
        send(mk(3'b011, 2'd3, 15'h5, 21'h0, 4'd1, 4'd1, 4'd1));
        idle(8);
        check("rdbad_err", 64'(err_cnt), 64'(6));
        check("rdbad_no_rsp", 64'(rq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
